// File: rtl/dx_iobus_ctrl_pkg.sv
// Shared types for the dx_iobus controller: FSM state encodings, pad
// direction constants and the counter preload helper.
package dx_iobus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TURN  = 3'd1,
        ST_WR    = 3'd2,
        ST_RWAIT = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic DRV = 1'b1;
    localparam logic REL = 1'b0;

    // The counter runs N cycles when loaded with N-1 and exits on its zero flag.
    function automatic logic [3:0] cnt_preload(input int cycles);
        return (cycles <= 0) ? 4'd0 : 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/dx_cnt_dn.sv
// Loadable 4-bit down-counter with a zero flag; shared by turnaround and read wait.
module dx_cnt_dn (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/dx_iobus_ctrl.sv
// Half-duplex pad bus controller: sequences dio_i/dio_t of a tristate pad bank
// with turnaround cycles on every direction change.
module dx_iobus_ctrl
    import dx_iobus_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int TURN_CYCLES = 1,
    parameter int RD_WAIT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid holds its payload until then, ready never waits on valid.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [DATA_WIDTH-1:0] dio_i,
    output logic [DATA_WIDTH-1:0] dio_t,
    input  logic [DATA_WIDTH-1:0] dio_o,
    output logic                  bus_stb,
    output logic                  bus_we,
    output logic                  busy,
    output state_t                dbg_state
);

    localparam logic [3:0] TURN_LOAD = cnt_preload(TURN_CYCLES);
    localparam logic [3:0] RD_LOAD   = cnt_preload(RD_WAIT);
    localparam logic       TURN_ZERO = (TURN_CYCLES == 0);

    state_t                state;
    logic                  drv;
    logic                  target_rd;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  accept;
    logic                  cnt_load;
    logic [3:0]            cnt_val;
    logic                  cnt_dec;
    logic                  cnt_zero;

    assign accept    = cmd_valid & cmd_ready;
    assign dio_t     = {DATA_WIDTH{~drv}};
    assign dbg_state = state;

    dx_cnt_dn u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Counter is preloaded on the edge that enters TURN or RWAIT.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = 4'd0;
        cnt_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_wr) begin
                        if (drv == REL && !TURN_ZERO) begin
                            cnt_load = 1'b1;
                            cnt_val  = TURN_LOAD;
                        end
                    end else begin
                        cnt_load = 1'b1;
                        cnt_val  = (drv == DRV && !TURN_ZERO) ? TURN_LOAD : RD_LOAD;
                    end
                end
            end
            ST_TURN: begin
                if (cnt_zero) begin
                    if (target_rd) begin
                        cnt_load = 1'b1;
                        cnt_val  = RD_LOAD;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RWAIT: cnt_dec = !cnt_zero;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            drv       <= REL;
            dio_i     <= '0;
            wr_data   <= '0;
            target_rd <= 1'b0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            bus_stb   <= 1'b0;
            bus_we    <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        wr_data   <= cmd_data;
                        target_rd <= !cmd_wr;
                        if (cmd_wr) begin
                            if (drv == DRV || TURN_ZERO) begin
                                state   <= ST_WR;
                                drv     <= DRV;
                                dio_i   <= cmd_data;
                                bus_stb <= 1'b1;
                                bus_we  <= 1'b1;
                            end else begin
                                state <= ST_TURN;
                            end
                        end else begin
                            // Release the pads on the accept edge so the read strobe never overlaps a drive.
                            drv <= REL;
                            if (drv == REL || TURN_ZERO) begin
                                state   <= ST_RWAIT;
                                bus_stb <= 1'b1;
                                bus_we  <= 1'b0;
                            end else begin
                                state <= ST_TURN;
                            end
                        end
                    end
                end
                ST_TURN: begin
                    if (cnt_zero) begin
                        bus_stb <= 1'b1;
                        if (target_rd) begin
                            state  <= ST_RWAIT;
                            bus_we <= 1'b0;
                        end else begin
                            state  <= ST_WR;
                            drv    <= DRV;
                            dio_i  <= wr_data;
                            bus_we <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    state     <= ST_IDLE;
                    bus_stb   <= 1'b0;
                    bus_we    <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                ST_RWAIT: begin
                    if (cnt_zero) begin
                        state     <= ST_RESP;
                        rsp_data  <= dio_o;
                        rsp_valid <= 1'b1;
                        bus_stb   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    bus_stb   <= 1'b0;
                    bus_we    <= 1'b0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dx_iobus_ctrl.sv
// Directed bench for dx_iobus_ctrl: instance 0 (T=1, W=2) for the directed
// scenarios, instances 1 (T=0) and 2 (T=3) for a scoreboarded command mix.
module tb_dx_iobus_ctrl;
    import dx_iobus_ctrl_pkg::*;

    localparam int W = 2;

    logic       clk;
    logic       rst;
    logic       cmd_valid [3];
    logic       cmd_wr    [3];
    logic [7:0] cmd_data  [3];
    logic       rsp_ready [3];
    logic [7:0] dev_val   [3];
    logic       model_drv [3];
    wire        cmd_ready [3];
    wire        rsp_valid [3];
    wire  [7:0] rsp_data  [3];
    wire  [7:0] dio_i     [3];
    wire  [7:0] dio_t     [3];
    wire  [7:0] dio_o     [3];
    wire        bus_stb   [3];
    wire        bus_we    [3];
    wire        busy      [3];
    wire  [2:0] dbg_state [3];

    logic [7:0] exp_q [$];
    int n_pass;
    int n_total;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dx_iobus_ctrl #(
            .DATA_WIDTH  (8),
            .TURN_CYCLES ((g == 1) ? 0 : ((g == 2) ? 3 : 1)),
            .RD_WAIT     (W)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_wr    (cmd_wr[g]),
            .cmd_data  (cmd_data[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_data  (rsp_data[g]),
            .dio_i     (dio_i[g]),
            .dio_t     (dio_t[g]),
            .dio_o     (dio_o[g]),
            .bus_stb   (bus_stb[g]),
            .bus_we    (bus_we[g]),
            .busy      (busy[g]),
            .dbg_state (dbg_state[g])
        );
        // Pad model: the device drives when the controller releases, else the pads echo dio_i.
        assign dio_o[g] = (dio_t[g] == 8'hFF) ? dev_val[g] : dio_i[g];
    end

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pads must never be driven while the device is strobed for a read.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                if (bus_stb[k] && !bus_we[k]) check("rd_invariant", dio_t[k], 8'hFF);
            end
        end
    end

    task automatic issue(input int k, input logic wr, input logic [7:0] data);
        cmd_wr[k]    = wr;
        cmd_data[k]  = data;
        cmd_valid[k] = 1'b1;
        tick();
        cmd_valid[k] = 1'b0;
    endtask

    task automatic run_cmd(input int k, input int t_cyc, input logic wr, input logic [7:0] data);
        int n;
        int exp_lat;
        int hold;
        logic [7:0] exp;
        n = 0;
        while (!cmd_ready[k] && n < 40) begin
            tick();
            n++;
        end
        check("ready_wait", cmd_ready[k], 1'b1);
        if (!wr) begin
            dev_val[k] = 8'($urandom_range(0, 255));
            exp_q.push_back(dev_val[k]);
        end
        issue(k, wr, data);
        n = 1;
        if (wr) begin
            exp_lat = model_drv[k] ? 1 : t_cyc + 1;
            while (!(bus_stb[k] && bus_we[k]) && n < 40) begin
                tick();
                n++;
            end
            check("wr_latency", n, exp_lat);
            check("wr_data", dio_i[k], data);
            check("wr_dir", dio_t[k], 8'h00);
            model_drv[k] = 1'b1;
        end else begin
            exp_lat = model_drv[k] ? t_cyc + W + 1 : W + 1;
            while (!rsp_valid[k] && n < 40) begin
                tick();
                n++;
            end
            check("rd_latency", n, exp_lat);
            hold = $urandom_range(0, 2);
            for (int j = 0; j < hold; j++) begin
                tick();
                check("rsp_hold", rsp_valid[k], 1'b1);
            end
            exp = exp_q.pop_front();
            check("rd_data", rsp_data[k], exp);
            rsp_ready[k] = 1'b1;
            tick();
            rsp_ready[k] = 1'b0;
            check("rsp_done", rsp_valid[k], 1'b0);
            model_drv[k] = 1'b0;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int k = 0; k < 3; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_wr[k]    = 1'b0;
            cmd_data[k]  = 8'h00;
            rsp_ready[k] = 1'b0;
            dev_val[k]   = 8'h00;
            model_drv[k] = 1'b0;
        end

        // Reset values.
        rst = 1'b0;
        #3;
        check("rst_dio_t", dio_t[0], 8'hFF);
        check("rst_dio_i", dio_i[0], 8'h00);
        check("rst_cmd_ready", cmd_ready[0], 1'b0);
        check("rst_rsp_valid", rsp_valid[0], 1'b0);
        check("rst_rsp_data", rsp_data[0], 8'h00);
        check("rst_bus_stb", bus_stb[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        tick();
        tick();
        rst = 1'b1;
        check("rel_cmd_ready_low", cmd_ready[0], 1'b0);
        tick();
        check("rel_cmd_ready_high", cmd_ready[0], 1'b1);

        // Write A5 from released bus: TURN in cycle 1, strobe in cycle 2.
        issue(0, 1'b1, 8'hA5);
        check("wa5_c1_state", dbg_state[0], ST_TURN);
        check("wa5_c1_dio_t", dio_t[0], 8'hFF);
        check("wa5_c1_stb", bus_stb[0], 1'b0);
        check("wa5_c1_busy", busy[0], 1'b1);
        tick();
        check("wa5_c2_dio_t", dio_t[0], 8'h00);
        check("wa5_c2_dio_i", dio_i[0], 8'hA5);
        check("wa5_c2_stb", bus_stb[0], 1'b1);
        check("wa5_c2_we", bus_we[0], 1'b1);
        tick();
        check("wa5_c3_stb", bus_stb[0], 1'b0);
        check("wa5_c3_hold", dio_i[0], 8'hA5);
        check("wa5_c3_dio_t", dio_t[0], 8'h00);
        check("wa5_c3_ready", cmd_ready[0], 1'b1);

        // Back-to-back writes 11 then 22, strobes two cycles apart.
        cmd_wr[0]    = 1'b1;
        cmd_data[0]  = 8'h11;
        cmd_valid[0] = 1'b1;
        tick();
        check("b2b1_stb", bus_stb[0], 1'b1);
        check("b2b1_dio_i", dio_i[0], 8'h11);
        check("b2b1_ready", cmd_ready[0], 1'b0);
        cmd_data[0] = 8'h22;
        tick();
        check("b2b_gap_stb", bus_stb[0], 1'b0);
        check("b2b_gap_ready", cmd_ready[0], 1'b1);
        tick();
        cmd_valid[0] = 1'b0;
        check("b2b2_stb", bus_stb[0], 1'b1);
        check("b2b2_dio_i", dio_i[0], 8'h22);
        tick();

        // Read after write, device drives 3C.
        dev_val[0] = 8'h3C;
        issue(0, 1'b0, 8'h00);
        check("rd_c1_dio_t", dio_t[0], 8'hFF);
        check("rd_c1_stb", bus_stb[0], 1'b0);
        check("rd_c1_state", dbg_state[0], ST_TURN);
        tick();
        check("rd_c2_stb", bus_stb[0], 1'b1);
        check("rd_c2_we", bus_we[0], 1'b0);
        tick();
        check("rd_c3_stb", bus_stb[0], 1'b1);
        tick();
        check("rd_c4_valid", rsp_valid[0], 1'b1);
        check("rd_c4_data", rsp_data[0], 8'h3C);
        check("rd_c4_stb", bus_stb[0], 1'b0);
        dev_val[0] = 8'h99;

        // Response stalled for five cycles.
        for (int j = 0; j < 5; j++) begin
            tick();
            check("stall_data", rsp_data[0], 8'h3C);
            check("stall_ready", cmd_ready[0], 1'b0);
            check("stall_valid", rsp_valid[0], 1'b1);
        end
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        check("rsp_idle_ready", cmd_ready[0], 1'b1);
        check("rsp_idle_valid", rsp_valid[0], 1'b0);
        check("rsp_idle_busy", busy[0], 1'b0);

        // Reset during the write strobe releases the pads without a clock.
        issue(0, 1'b1, 8'h5A);
        tick();
        check("wr5a_dio_t", dio_t[0], 8'h00);
        #2;
        rst = 1'b0;
        #1;
        check("arst_wr_dio_t", dio_t[0], 8'hFF);
        check("arst_wr_dio_i", dio_i[0], 8'h00);
        check("arst_wr_stb", bus_stb[0], 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Reset in the middle of RWAIT drops the read.
        issue(0, 1'b0, 8'h00);
        check("rw_c1_stb", bus_stb[0], 1'b1);
        check("rw_c1_state", dbg_state[0], ST_RWAIT);
        #2;
        rst = 1'b0;
        #1;
        check("arst_rd_stb", bus_stb[0], 1'b0);
        check("arst_rd_valid", rsp_valid[0], 1'b0);
        check("arst_rd_dio_t", dio_t[0], 8'hFF);
        check("arst_rd_busy", busy[0], 1'b0);
        tick();
        rst = 1'b1;
        check("arst_rel_ready_low", cmd_ready[0], 1'b0);
        tick();
        check("arst_rel_ready_high", cmd_ready[0], 1'b1);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("arst_no_rsp", rsp_valid[0], 1'b0);
        end

        // Scoreboarded command mix at T=0 and T=3.
        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                run_cmd(k, (k == 1) ? 0 : 3, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
        end
        check("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
